// File: rtl/lane_sensor_conditioner.sv
// Per-lane sensor conditioning for the 4-way light controller: queue counts with
// jam hysteresis, empty qualification, siren debounce and a single-owner emergency arbiter.
module lane_sensor_conditioner #(
  parameter int CNT_W      = 6,
  parameter int JAM_TH     = 20,
  parameter int JAM_CLR    = 12,
  parameter int EMPTY_HOLD = 8,
  parameter int DEB_LEN    = 3,
  parameter int EMG_HOLD   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [3:0]           veh_in,
  input  logic [3:0]           veh_out,
  input  logic [3:0]           siren_raw,
  output logic [3:0]           emergency,
  output logic [3:0]           jam,
  output logic [3:0]           empty,
  output logic [4*CNT_W-1:0]   q_count
);

  localparam int ZW = $clog2(EMPTY_HOLD + 1);
  localparam int DW = $clog2(DEB_LEN + 1);
  localparam int HW = $clog2(EMG_HOLD + 1);

  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] JAM_TH_C  = CNT_W'(JAM_TH);
  localparam logic [CNT_W-1:0] JAM_CLR_C = CNT_W'(JAM_CLR);
  localparam logic [ZW-1:0]    ZR_MAX    = ZW'(EMPTY_HOLD);
  localparam logic [ZW-1:0]    ZR_LAST   = ZW'(EMPTY_HOLD - 1);
  localparam logic [DW-1:0]    DEB_MAX   = DW'(DEB_LEN);
  localparam logic [HW-1:0]    HOLD_LAST = HW'(EMG_HOLD - 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACTIVE = 2'd1;
  localparam logic [1:0] ST_HOLD   = 2'd2;

  logic [CNT_W-1:0] r_cnt [4];
  logic [ZW-1:0]    r_zr  [4];
  logic [DW-1:0]    r_run [4];
  logic [3:0]       r_jam;
  logic [3:0]       r_empty;
  logic [3:0]       r_emg;
  logic [1:0]       r_state;
  logic [1:0]       r_owner;
  logic [HW-1:0]    r_hold;
  logic [3:0]       w_sirq;
  logic [1:0]       w_low;

  // Per-lane counters: queue depth, jam hysteresis, zero-run/empty and siren run length.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        r_cnt[i] <= '0;
        r_zr[i]  <= '0;
        r_run[i] <= '0;
      end
      r_jam   <= 4'b0000;
      r_empty <= 4'b0000;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (veh_in[i] && !veh_out[i] && (r_cnt[i] != CNT_MAX)) begin
          r_cnt[i] <= r_cnt[i] + 1'b1;
        end else if (veh_out[i] && !veh_in[i] && (r_cnt[i] != '0)) begin
          r_cnt[i] <= r_cnt[i] - 1'b1;
        end else begin
          r_cnt[i] <= r_cnt[i];
        end

        // Jam follows the count one cycle late; the band between thresholds holds.
        if (r_cnt[i] >= JAM_TH_C) begin
          r_jam[i] <= 1'b1;
        end else if (r_cnt[i] <= JAM_CLR_C) begin
          r_jam[i] <= 1'b0;
        end else begin
          r_jam[i] <= r_jam[i];
        end

        if (r_cnt[i] == '0) begin
          if (r_zr[i] != ZR_MAX) begin
            r_zr[i] <= r_zr[i] + 1'b1;
          end else begin
            r_zr[i] <= r_zr[i];
          end
          r_empty[i] <= (r_zr[i] >= ZR_LAST);
        end else begin
          r_zr[i]    <= '0;
          r_empty[i] <= 1'b0;
        end

        if (siren_raw[i]) begin
          if (r_run[i] != DEB_MAX) begin
            r_run[i] <= r_run[i] + 1'b1;
          end else begin
            r_run[i] <= r_run[i];
          end
        end else begin
          r_run[i] <= '0;
        end
      end
    end
  end

  // Qualified sirens and the lowest-index qualified lane.
  always_comb begin
    w_sirq = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      w_sirq[i] = (r_run[i] == DEB_MAX);
    end
    if (w_sirq[0]) begin
      w_low = 2'd0;
    end else if (w_sirq[1]) begin
      w_low = 2'd1;
    end else if (w_sirq[2]) begin
      w_low = 2'd2;
    end else begin
      w_low = 2'd3;
    end
  end

  // Emergency arbiter: the owner keeps the grant until its siren has been gone EMG_HOLD cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_owner <= 2'd0;
      r_hold  <= '0;
      r_emg   <= 4'b0000;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (|w_sirq) begin
            r_state <= ST_ACTIVE;
            r_owner <= w_low;
            r_emg   <= 4'b0001 << w_low;
          end else begin
            r_emg   <= 4'b0000;
          end
        end
        ST_ACTIVE: begin
          if (!w_sirq[r_owner]) begin
            r_state <= ST_HOLD;
            r_hold  <= '0;
          end else begin
            r_state <= ST_ACTIVE;
          end
        end
        ST_HOLD: begin
          if (w_sirq[r_owner]) begin
            r_state <= ST_ACTIVE;
          end else if (r_hold == HOLD_LAST) begin
            r_state <= ST_IDLE;
            r_emg   <= 4'b0000;
          end else begin
            r_hold  <= r_hold + 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_emg   <= 4'b0000;
        end
      endcase
    end
  end

  // Output mapping; every output is a register.
  always_comb begin
    q_count = '0;
    for (int i = 0; i < 4; i++) begin
      q_count[i*CNT_W +: CNT_W] = r_cnt[i];
    end
    emergency = r_emg;
    jam       = r_jam;
    empty     = r_empty;
  end

endmodule

// File: tb/tb_lane_sensor_conditioner.sv
// Scoreboard bench: stimulus pushes expected outputs from a behavioural lane model,
// a monitor pops and compares them one cycle later.
module tb_lane_sensor_conditioner;
  localparam int CW = 6;

  logic            clk;
  logic            rst;
  logic [3:0]      veh_in, veh_out, siren_raw;
  logic [3:0]      emergency, jam, empty;
  logic [4*CW-1:0] q_count;

  typedef struct packed {
    logic [3:0]      emg;
    logic [3:0]      jam;
    logic [3:0]      empty;
    logic [4*CW-1:0] q;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  // Model: lane depth, consecutive zero edges, consecutive siren-high samples,
  // current emergency owner and edges since its siren was last qualified.
  int m_cnt[4], m_streak[4], m_highs[4];
  bit m_jam[4];
  int m_owner = -1;
  int m_lost  = 0;

  lane_sensor_conditioner dut (
    .clk(clk), .rst(rst), .veh_in(veh_in), .veh_out(veh_out), .siren_raw(siren_raw),
    .emergency(emergency), .jam(jam), .empty(empty), .q_count(q_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp_v, $time);
    end
  endtask

  task automatic step(input logic [3:0] vi, input logic [3:0] vo, input logic [3:0] sr, input logic r);
    exp_t e;
    int   lowest;
    logic [3:0] one;
    @(negedge clk);
    veh_in = vi; veh_out = vo; siren_raw = sr; rst = r;
    if (r) begin
      for (int i = 0; i < 4; i++) begin
        m_cnt[i] = 0; m_streak[i] = 0; m_highs[i] = 0; m_jam[i] = 1'b0;
      end
      m_owner = -1; m_lost = 0;
    end else begin
      if (m_owner < 0) begin
        lowest = -1;
        for (int i = 3; i >= 0; i--) if (m_highs[i] >= 3) lowest = i;
        if (lowest >= 0) begin m_owner = lowest; m_lost = 0; end
      end else begin
        if (m_highs[m_owner] >= 3) m_lost = 0;
        else m_lost++;
        if (m_lost > 16) m_owner = -1;
      end
      for (int i = 0; i < 4; i++) begin
        if (m_cnt[i] >= 20) m_jam[i] = 1'b1;
        else if (m_cnt[i] <= 12) m_jam[i] = 1'b0;
        m_streak[i] = (m_cnt[i] == 0) ? m_streak[i] + 1 : 0;
        if (vi[i] && !vo[i] && m_cnt[i] < 63) m_cnt[i]++;
        else if (vo[i] && !vi[i] && m_cnt[i] > 0) m_cnt[i]--;
        m_highs[i] = sr[i] ? m_highs[i] + 1 : 0;
      end
    end
    one = 4'b0001;
    e.emg = (m_owner >= 0) ? (one << m_owner) : 4'b0000;
    for (int i = 0; i < 4; i++) begin
      e.jam[i]   = m_jam[i];
      e.empty[i] = (m_streak[i] >= 8);
      e.q[i*CW +: CW] = CW'(m_cnt[i]);
    end
    sb.push_back(e);
  endtask

  task automatic run(input int n, input logic [3:0] vi, input logic [3:0] vo, input logic [3:0] sr);
    for (int k = 0; k < n; k++) step(vi, vo, sr, 1'b0);
  endtask

  // Monitor: one expected record per clock edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("emergency", {28'd0, emergency}, {28'd0, e.emg});
        chk("jam",       {28'd0, jam},       {28'd0, e.jam});
        chk("empty",     {28'd0, empty},     {28'd0, e.empty});
        chk("q_count",   {8'd0, q_count},    {8'd0, e.q});
      end
    end
  end

  initial begin
    logic [3:0] lev, vi, vo, sr;
    int pin, pout;
    rst = 1'b1; veh_in = 4'b0000; veh_out = 4'b0000; siren_raw = 4'b0000;
    step(4'b0000, 4'b0000, 4'b0000, 1'b1);
    step(4'b0000, 4'b0000, 4'b0000, 1'b1);
    run(20, 4'b0000, 4'b0000, 4'b0000);
    // Jam hysteresis on E.
    run(21, 4'b0100, 4'b0000, 4'b0000);
    run(2,  4'b0000, 4'b0000, 4'b0000);
    run(9,  4'b0000, 4'b0100, 4'b0000);
    run(3,  4'b0000, 4'b0000, 4'b0000);
    // Simultaneous pulses, saturation, underflow.
    run(3,  4'b0001, 4'b0000, 4'b0000);
    run(5,  4'b0001, 4'b0001, 4'b0000);
    run(70, 4'b0010, 4'b0000, 4'b0000);
    run(8,  4'b0000, 4'b0001, 4'b0000);
    run(2,  4'b0000, 4'b0000, 4'b0000);
    // Glitchy siren on S.
    run(2,  4'b0000, 4'b0000, 4'b0010);
    run(1,  4'b0000, 4'b0000, 4'b0000);
    run(10, 4'b0000, 4'b0000, 4'b0010);
    run(25, 4'b0000, 4'b0000, 4'b0000);
    // E and W together: E owns, W waits through the hold.
    run(10, 4'b0000, 4'b0000, 4'b1100);
    run(30, 4'b0000, 4'b0000, 4'b1000);
    run(25, 4'b0000, 4'b0000, 4'b0000);
    // Reset mid-emergency with N jammed.
    run(22, 4'b0001, 4'b0000, 4'b0001);
    step(4'b0001, 4'b0000, 4'b0001, 1'b1);
    run(10, 4'b0001, 4'b0000, 4'b0001);
    run(20, 4'b0000, 4'b0000, 4'b0000);
    // Random traffic with glitchy sirens and occasional resets.
    lev = 4'b0000;
    for (int blk = 0; blk < 4; blk++) begin
      pin  = (blk % 2 == 0) ? 55 : 20;
      pout = (blk % 2 == 0) ? 20 : 55;
      for (int c = 0; c < 200; c++) begin
        for (int i = 0; i < 4; i++) begin
          vi[i] = ($urandom_range(0, 99) < pin);
          vo[i] = ($urandom_range(0, 99) < pout);
          if ($urandom_range(0, 99) < 6) lev[i] = ~lev[i];
          sr[i] = ($urandom_range(0, 99) < 5) ? ~lev[i] : lev[i];
        end
        step(vi, vo, sr, ($urandom_range(0, 299) == 0));
      end
    end
    run(40, 4'b0000, 4'b0000, 4'b0000);
    @(posedge clk);
    #3;
    chk("scoreboard_drained", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
